// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcode constants, FSM encoding and
// the opcode legality check.
package alu_pkg;

    localparam logic [2:0] OpAnd = 3'b000;
    localparam logic [2:0] OpOr  = 3'b001;
    localparam logic [2:0] OpAdd = 3'b010;
    localparam logic [2:0] OpSub = 3'b110;
    localparam logic [2:0] OpSlt = 3'b111;
    localparam logic [2:0] OpSll = 3'b101;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

    function automatic logic is_legal_op(input logic [2:0] op);
        return op inside {OpAnd, OpOr, OpAdd, OpSub, OpSlt, OpSll};
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot grant, priority pointer
// moves to the losing requester whenever a grant is taken.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    // prio_q = 0: requester 0 wins a tie; 1: requester 1 wins.
    logic prio_q;

    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = prio_q ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q <= 1'b0;
        end else if (advance && (grant != 2'b00)) begin
            prio_q <= grant[0];
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters; each accepted
// op runs IDLE -> EXEC -> RESP (illegal opcodes skip EXEC and return an error).
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_data,
    output logic             rsp0_err,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_data,
    output logic             rsp1_err,
    output logic [WIDTH-1:0] alu_dataA,
    output logic [WIDTH-1:0] alu_dataB,
    output logic [2:0]       alu_signal,
    input  logic [WIDTH-1:0] alu_dataOut
);

    state_e           state_q, state_d;
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;

    logic [1:0]       arb_valid;
    logic [1:0]       grant;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [2:0]       sel_op;

    // Grants only happen in IDLE and never while reset is asserted.
    assign arb_valid = (state_q == StIdle && !reset) ? {req1_valid, req0_valid} : 2'b00;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .valid   (arb_valid),
        .advance (|grant),
        .grant   (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    assign sel_a  = grant[1] ? req1_a  : req0_a;
    assign sel_b  = grant[1] ? req1_b  : req0_b;
    assign sel_op = grant[1] ? req1_op : req0_op;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            StIdle: begin
                if (grant != 2'b00) begin
                    owner_d = grant[1];
                    if (is_legal_op(sel_op)) begin
                        a_d     = sel_a;
                        b_d     = sel_b;
                        op_d    = sel_op;
                        state_d = StExec;
                    end else begin
                        result_d = '0;
                        err_d    = 1'b1;
                        state_d  = StResp;
                    end
                end
            end
            StExec: begin
                result_d = alu_dataOut;
                err_d    = 1'b0;
                state_d  = StResp;
            end
            StResp: begin
                if (owner_q ? rsp1_ready : rsp0_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            owner_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 3'b000;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign rsp0_valid = (state_q == StResp) && !owner_q;
    assign rsp1_valid = (state_q == StResp) && owner_q;
    assign rsp0_data  = result_q;
    assign rsp1_data  = result_q;
    assign rsp0_err   = err_q && rsp0_valid;
    assign rsp1_err   = err_q && rsp1_valid;

    assign alu_dataA  = a_q;
    assign alu_dataB  = b_q;
    assign alu_signal = op_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level model.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready, rsp1_ready;
    logic [31:0] rsp0_data, rsp1_data;
    logic        rsp0_err, rsp1_err;
    logic [31:0] alu_dataA, alu_dataB, alu_dataOut;
    logic [2:0]  alu_signal;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b101:  return a << b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    // Stand-in for the external shared ALU.
    assign alu_dataOut = alu_f(alu_signal, alu_dataA, alu_dataB);

    alu_arbiter #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_data  (rsp0_data),
        .rsp0_err   (rsp0_err),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_data  (rsp1_data),
        .rsp1_err   (rsp1_err),
        .alu_dataA  (alu_dataA),
        .alu_dataB  (alu_dataB),
        .alu_signal (alu_signal),
        .alu_dataOut(alu_dataOut)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req0_op = 0;
        req1_a = 0; req1_b = 0; req1_op = 0;
        rsp0_ready = 1; rsp1_ready = 1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        logic [31:0] outs;
        clear_inputs();
        reset = 1;
        req0_valid = 1; req1_valid = 1;
        tick();
        @(negedge clk);
        outs = {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err};
        checks++;
        if (outs !== 32'd0) begin
            failures++; $display("FAIL reset_flags: got %0h want 0", outs);
        end
        checks++;
        if ({alu_dataA, alu_dataB, alu_signal} !== 67'd0) begin
            failures++;
            $display("FAIL reset_alu: got %0h %0h %0h want 0", alu_dataA, alu_dataB, alu_signal);
        end
        checks++;
        if (rsp0_data !== 32'd0) begin
            failures++; $display("FAIL reset_result: got %0h want 0", rsp0_data);
        end
        reset = 0;
        req0_valid = 0; req1_valid = 0;
        tick();
    endtask

    task automatic test_single_add();
        req0_op = 3'b010; req0_a = 5; req0_b = 7; req0_valid = 1;
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            failures++; $display("FAIL add_grant: got %b want 10", {req0_ready, req1_ready});
        end
        tick();
        req0_valid = 0;
        @(negedge clk);
        checks++;
        if ({rsp0_valid, rsp1_valid, alu_dataA, alu_signal} !== {2'b00, 32'd5, 3'b010}) begin
            failures++;
            $display("FAIL add_exec: got v=%b%b a=%0h sig=%0h want v=00 a=5 sig=2",
                     rsp0_valid, rsp1_valid, alu_dataA, alu_signal);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({rsp0_valid, rsp1_valid, rsp0_data, rsp0_err} !== {2'b10, 32'd12, 1'b0}) begin
            failures++;
            $display("FAIL add_resp: got v=%b%b data=%0h err=%b want v=10 data=c err=0",
                     rsp0_valid, rsp1_valid, rsp0_data, rsp0_err);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
            failures++; $display("FAIL add_done: got %b%b want 00", rsp0_valid, rsp1_valid);
        end
        tick();
    endtask

    // Runs right after test_single_add, so alu_signal still shows ADD.
    task automatic test_illegal();
        req1_op = 3'b011; req1_a = 1; req1_b = 1; req1_valid = 1;
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            failures++; $display("FAIL illegal_grant: got %b want 01", {req0_ready, req1_ready});
        end
        tick();
        req1_valid = 0;
        @(negedge clk);
        checks++;
        if ({rsp0_valid, rsp1_valid, rsp1_err, rsp1_data} !== {3'b011, 32'd0}) begin
            failures++;
            $display("FAIL illegal_resp: got v=%b%b err=%b data=%0h want v=01 err=1 data=0",
                     rsp0_valid, rsp1_valid, rsp1_err, rsp1_data);
        end
        checks++;
        if ({alu_signal, alu_dataA} !== {3'b010, 32'd5}) begin
            failures++;
            $display("FAIL illegal_alu_hold: got sig=%0h a=%0h want sig=2 a=5",
                     alu_signal, alu_dataA);
        end
        tick();
        @(negedge clk);
        checks++;
        if (rsp1_valid !== 1'b0) begin
            failures++; $display("FAIL illegal_done: got %b want 0", rsp1_valid);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int exp;
        do_reset();
        req0_op = 3'b110; req0_a = 10;    req0_b = 3;    req0_valid = 1;
        req1_op = 3'b001; req1_a = 'hF0;  req1_b = 'h0F; req1_valid = 1;
        exp = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if ({req1_ready, req0_ready} !== (exp == 0 ? 2'b01 : 2'b10)) begin
                failures++;
                $display("FAIL alt_grant[%0d]: got r1r0=%b want owner %0d", k,
                         {req1_ready, req0_ready}, exp);
            end
            tick();
            @(negedge clk);
            checks++;
            if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 4'b0000) begin
                failures++;
                $display("FAIL alt_exec[%0d]: got %b want 0000", k,
                         {req0_ready, req1_ready, rsp0_valid, rsp1_valid});
            end
            tick();
            @(negedge clk);
            checks++;
            if (exp == 0 && {rsp0_valid, rsp1_valid, rsp0_data} !== {2'b10, 32'd7}) begin
                failures++;
                $display("FAIL alt_resp0[%0d]: got v=%b%b data=%0h want v=10 data=7", k,
                         rsp0_valid, rsp1_valid, rsp0_data);
            end
            if (exp == 1 && {rsp0_valid, rsp1_valid, rsp1_data} !== {2'b01, 32'hFF}) begin
                failures++;
                $display("FAIL alt_resp1[%0d]: got v=%b%b data=%0h want v=01 data=ff", k,
                         rsp0_valid, rsp1_valid, rsp1_data);
            end
            tick();
            exp = 1 - exp;
        end
        clear_inputs();
    endtask

    task automatic test_backpressure();
        do_reset();
        req0_op = 3'b000; req0_a = 32'hFFFF0000; req0_b = 32'h12345678; req0_valid = 1;
        req1_op = 3'b010; req1_a = 2; req1_b = 3; req1_valid = 1;
        rsp0_ready = 0;
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            failures++; $display("FAIL bp_grant: got %b want 10", {req0_ready, req1_ready});
        end
        tick();
        req0_valid = 0;
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({rsp0_valid, rsp0_data, req1_ready} !== {1'b1, 32'h12340000, 1'b0}) begin
                failures++;
                $display("FAIL bp_hold[%0d]: got v=%b data=%0h r1=%b want v=1 data=12340000 r1=0",
                         i, rsp0_valid, rsp0_data, req1_ready);
            end
            tick();
        end
        rsp0_ready = 1;
        @(negedge clk);
        checks++;
        if ({rsp0_valid, req1_ready} !== 2'b10) begin
            failures++; $display("FAIL bp_release: got %b want 10", {rsp0_valid, req1_ready});
        end
        tick();
        rsp0_ready = 0;
        @(negedge clk);
        checks++;
        if ({rsp0_valid, req1_ready} !== 2'b01) begin
            failures++; $display("FAIL bp_next_grant: got %b want 01", {rsp0_valid, req1_ready});
        end
        tick();
        req1_valid = 0;
        tick();
        @(negedge clk);
        checks++;
        if ({rsp1_valid, rsp1_data} !== {1'b1, 32'd5}) begin
            failures++;
            $display("FAIL bp_req1_resp: got v=%b data=%0h want v=1 data=5", rsp1_valid, rsp1_data);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req0_op = 3'b010; req0_a = 1; req0_b = 1; req0_valid = 1;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1) begin
            failures++; $display("FAIL rm_grant: got %b want 1", req0_ready);
        end
        tick();
        req0_valid = 0;
        reset = 1;
        @(negedge clk);
        checks++;
        if ({rsp0_valid, req0_ready} !== 2'b00) begin
            failures++; $display("FAIL rm_exec: got %b want 00", {rsp0_valid, req0_ready});
        end
        tick();
        @(negedge clk);
        checks++;
        if ({rsp0_valid, rsp1_valid, rsp0_err, alu_dataA, alu_dataB, alu_signal} !== 70'd0) begin
            failures++;
            $display("FAIL rm_cleared: got v=%b%b err=%b a=%0h b=%0h sig=%0h want all 0",
                     rsp0_valid, rsp1_valid, rsp0_err, alu_dataA, alu_dataB, alu_signal);
        end
        reset = 0;
        tick();
        @(negedge clk);
        checks++;
        if (rsp0_valid !== 1'b0) begin
            failures++; $display("FAIL rm_no_resp: got %b want 0", rsp0_valid);
        end
        tick();
        req0_valid = 1;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1) begin
            failures++; $display("FAIL rm_reissue_grant: got %b want 1", req0_ready);
        end
        tick();
        req0_valid = 0;
        tick();
        @(negedge clk);
        checks++;
        if ({rsp0_valid, rsp0_data, rsp0_err} !== {1'b1, 32'd2, 1'b0}) begin
            failures++;
            $display("FAIL rm_reissue_resp: got v=%b data=%0h err=%b want v=1 data=2 err=0",
                     rsp0_valid, rsp0_data, rsp0_err);
        end
        tick();
        clear_inputs();
    endtask

    // Transaction-level model: one op in flight, round-robin tie break,
    // response 2 cycles after a legal grant or 1 after an illegal one.
    task automatic test_random();
        bit          busy, owner, prio, granted, g, legal, exp_err;
        int          wait_cycles;
        logic [31:0] exp_a, exp_b, exp_data, ga, gb;
        logic [2:0]  exp_sig, gop;
        bit          rv0, rv1;
        do_reset();
        busy = 0; owner = 0; prio = 0; wait_cycles = 0;
        exp_a = 0; exp_b = 0; exp_sig = 0; exp_data = 0; exp_err = 0;
        for (int c = 0; c < 400; c++) begin
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            req0_op = 3'($urandom_range(0, 7));
            req1_op = 3'($urandom_range(0, 7));
            req0_a = $urandom; req0_b = $urandom_range(0, 40);
            req1_a = $urandom; req1_b = $urandom;
            rsp0_ready = 1'($urandom_range(0, 1));
            rsp1_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            granted = !busy && (req0_valid || req1_valid);
            g = (req0_valid && req1_valid) ? prio : req1_valid && !req0_valid;
            checks++;
            if ({req0_ready, req1_ready} !== {granted && !g, granted && g}) begin
                failures++;
                $display("FAIL rnd_ready[%0d]: got %b want %b", c, {req0_ready, req1_ready},
                         {granted && !g, granted && g});
            end
            rv0 = busy && wait_cycles == 0 && !owner;
            rv1 = busy && wait_cycles == 0 && owner;
            checks++;
            if ({rsp0_valid, rsp1_valid} !== {rv0, rv1}) begin
                failures++;
                $display("FAIL rnd_rsp_valid[%0d]: got %b want %b", c, {rsp0_valid, rsp1_valid},
                         {rv0, rv1});
            end
            if (rv0 || rv1) begin
                checks++;
                if ((rv0 ? {rsp0_data, rsp0_err} : {rsp1_data, rsp1_err}) !== {exp_data, exp_err})
                begin
                    failures++;
                    $display("FAIL rnd_rsp_data[%0d]: got %0h/%b want %0h/%b", c,
                             rv0 ? rsp0_data : rsp1_data, rv0 ? rsp0_err : rsp1_err,
                             exp_data, exp_err);
                end
            end
            checks++;
            if ({alu_dataA, alu_dataB, alu_signal} !== {exp_a, exp_b, exp_sig}) begin
                failures++;
                $display("FAIL rnd_alu_drive[%0d]: got %0h %0h %0h want %0h %0h %0h", c,
                         alu_dataA, alu_dataB, alu_signal, exp_a, exp_b, exp_sig);
            end
            if (granted) begin
                gop = g ? req1_op : req0_op;
                ga  = g ? req1_a : req0_a;
                gb  = g ? req1_b : req0_b;
                legal = gop != 3'b011 && gop != 3'b100;
                busy = 1; owner = g; prio = !g;
                wait_cycles = legal ? 1 : 0;
                exp_data = legal ? alu_f(gop, ga, gb) : 32'd0;
                exp_err = !legal;
                if (legal) begin
                    exp_a = ga; exp_b = gb; exp_sig = gop;
                end
            end else if (busy && wait_cycles > 0) begin
                wait_cycles--;
            end else if (busy && (owner ? rsp1_ready : rsp0_ready)) begin
                busy = 0;
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset = 0;
        tick();
        test_reset();
        test_single_add();
        test_illegal();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
